// File: rtl/ex_mem_pipe_skid.sv
// ex_mem_pipe_skid
//   Elastic pipeline stage register for the EX->MEM boundary (or any later
//   stage pair). Carries a packed stage bundle using a valid/ready handshake.
//   A two-entry skid buffer (main + skid) lets in_ready come straight from a
//   flop, so no combinational ready path runs between stages. Flush kills both
//   entries synchronously and takes priority over all traffic.
//
// Parameters
//   DATA_W        width of the packed stage bundle
//   CLR_ON_FLUSH  1: data registers are zeroed on Rst/Flush (the bubble is an
//                 all-zero nop); 0: only the valid bits are cleared
//
// Ports
//   Clk        clock; all state updates on posedge
//   Rst        synchronous, active-high reset
//   Flush      synchronous kill of both entries
//   in_valid   upstream bundle valid
//   in_ready   stage can accept (registered; high when the skid entry is empty)
//   in_data    upstream bundle
//   out_valid  main entry valid
//   out_ready  downstream accepts
//   out_data   main entry bundle
//   occ        number of entries held (0, 1 or 2)
module ex_mem_pipe_skid #(
  parameter int unsigned DATA_W       = 229,
  parameter bit          CLR_ON_FLUSH = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  logic              m_v;
  logic              s_v;
  logic [DATA_W-1:0] m_d;
  logic [DATA_W-1:0] s_d;
  logic              acc;
  logic              pop;

  assign acc = in_valid & ~s_v;
  assign pop = m_v & out_ready;

  always_ff @(posedge Clk) begin
    if (Rst || Flush) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      if (CLR_ON_FLUSH) begin
        m_d <= '0;
        s_d <= '0;
      end
    end else if (!m_v) begin
      // Empty: any accepted bundle lands directly in the main entry.
      if (acc) begin
        m_v <= 1'b1;
        m_d <= in_data;
      end
    end else if (!s_v) begin
      // One entry held.
      if (acc && pop) begin
        m_d <= in_data;
      end else if (acc) begin
        // Downstream stalled: park the new bundle in the skid entry.
        s_v <= 1'b1;
        s_d <= in_data;
      end else if (pop) begin
        m_v <= 1'b0;
      end
    end else if (pop) begin
      // Full: in_ready is low, so only a drain can happen.
      m_d <= s_d;
      s_v <= 1'b0;
    end
  end

  assign out_valid = m_v;
  assign out_data  = m_d;
  assign in_ready  = ~s_v;
  // s_v implies m_v, so the count is just these two bits.
  assign occ       = {s_v, m_v & ~s_v};

endmodule
